// File: rtl/axis_biquad_cascade_filter.sv
// ---------------------------------------------------------------------------
// axis_biquad_cascade_filter
//
// Time-multiplexed cascade of Direct-Form-1 biquad sections. A single shared
// multiplier/adder datapath walks the active sections once per rising edge
// of the decimation strobe. Each section keeps its own coefficients and
// x1/x2/y1/y2 history. Intermediate values carry internal_extra guard
// fraction bits and saturate instead of wrapping.
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   config_addr/data     shared configuration bus (data = 16 x 32-bit words)
//                          base+k        : section k coefficients
//                                          (w0=b0 w1=b1 w2=b2 w4=a1 w5=a2)
//                          base+sections : control word (w0[3:0] = active)
//   S_AXIS_in_tdata      signed input sample, latched on a strobe edge
//   S_AXIS_in_tvalid     forwarded to the pass port only
//   axis_decii_clk       decimation strobe (level; rising edge triggers)
//   M_AXIS_out_tdata     filtered output, held between updates
//   M_AXIS_out_tvalid    one-cycle pulse per new output
//   M_AXIS_pass_*        combinational copy of the input stream
//   overrun              sticky: strobe edge seen while the cascade was busy
// ---------------------------------------------------------------------------
module axis_biquad_cascade_filter #(
    parameter int signal_width          = 32,
    parameter int coefficient_width     = 32,
    parameter int coefficient_Q         = 28,
    parameter int internal_extra        = 4,
    parameter int sections              = 4,
    parameter int configuration_address = 999
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [31:0]                    config_addr,
    input  logic [511:0]                   config_data,
    input  logic signed [signal_width-1:0] S_AXIS_in_tdata,
    input  logic                           S_AXIS_in_tvalid,
    input  logic                           axis_decii_clk,
    output logic signed [signal_width-1:0] M_AXIS_out_tdata,
    output logic                           M_AXIS_out_tvalid,
    output logic signed [signal_width-1:0] M_AXIS_pass_tdata,
    output logic                           M_AXIS_pass_tvalid,
    output logic                           overrun
);

    localparam int DW    = signal_width;
    localparam int CW    = coefficient_width;
    localparam int IW    = signal_width + internal_extra;
    localparam int PW    = IW + CW;
    localparam int AW    = PW + 3;
    localparam int ACT_W = 4;
    localparam int IDX_W = (sections > 1) ? $clog2(sections) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PROD = 2'd1;
    localparam logic [1:0] ST_SUM  = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    // Full-precision signed product; operands are widened before multiplying
    function automatic logic signed [PW-1:0] mul(input logic signed [CW-1:0] c,
                                                 input logic signed [IW-1:0] d);
        logic signed [PW-1:0] ce;
        logic signed [PW-1:0] de;
        ce  = PW'(c);
        de  = PW'(d);
        mul = ce * de;
    endfunction

    // Clamp a shifted accumulator into the internal (guard-bit) width
    function automatic logic signed [IW-1:0] sat_int(input logic signed [AW-1:0] a);
        if (a[AW-1:IW-1] == {(AW-IW+1){a[AW-1]}})
            sat_int = a[IW-1:0];
        else if (a[AW-1])
            sat_int = {1'b1, {(IW-1){1'b0}}};
        else
            sat_int = {1'b0, {(IW-1){1'b1}}};
    endfunction

    // Clamp an internal value into the output sample width
    function automatic logic signed [DW-1:0] sat_out(input logic signed [IW-1:0] a);
        if (a[IW-1:DW-1] == {(IW-DW+1){a[IW-1]}})
            sat_out = a[DW-1:0];
        else if (a[IW-1])
            sat_out = {1'b1, {(DW-1){1'b0}}};
        else
            sat_out = {1'b0, {(DW-1){1'b1}}};
    endfunction

    // Per-section coefficients and history
    logic signed [CW-1:0] coef_b0 [sections];
    logic signed [CW-1:0] coef_b1 [sections];
    logic signed [CW-1:0] coef_b2 [sections];
    logic signed [CW-1:0] coef_a1 [sections];
    logic signed [CW-1:0] coef_a2 [sections];
    logic signed [IW-1:0] x1 [sections];
    logic signed [IW-1:0] x2 [sections];
    logic signed [IW-1:0] y1 [sections];
    logic signed [IW-1:0] y2 [sections];

    logic [1:0]           state;
    logic [IDX_W-1:0]     k;
    logic [ACT_W-1:0]     active;
    logic                 strobe_p0;
    logic                 strobe_p1;
    logic                 strobe_rise;
    logic signed [IW-1:0] v_p0;
    logic signed [PW-1:0] prod_b0_p1;
    logic signed [PW-1:0] prod_b1_p1;
    logic signed [PW-1:0] prod_b2_p1;
    logic signed [PW-1:0] prod_a1_p1;
    logic signed [PW-1:0] prod_a2_p1;
    logic signed [AW-1:0] acc_s;
    logic signed [IW-1:0] y_s;
    logic                 last_section;

    logic [sections-1:0]  cfg_sec_hit;
    logic                 cfg_sec_any;
    logic                 cfg_ctrl;
    logic [ACT_W-1:0]     cfg_active;
    logic                 cfg_unused;

    assign M_AXIS_pass_tdata  = S_AXIS_in_tdata;
    assign M_AXIS_pass_tvalid = S_AXIS_in_tvalid;

    always_comb begin
        cfg_sec_hit = '0;
        for (int i = 0; i < sections; i++)
            cfg_sec_hit[i] = (config_addr == 32'(configuration_address + i));
    end

    assign cfg_sec_any = |cfg_sec_hit;
    assign cfg_ctrl    = (config_addr == 32'(configuration_address + sections));
    assign cfg_active  = (config_data[3:0] > ACT_W'(sections)) ? ACT_W'(sections)
                                                                : config_data[3:0];
    // w3 and w6..w15 carry nothing for this block
    assign cfg_unused  = ^{config_data[127:96], config_data[511:192]};

    assign strobe_rise  = strobe_p0 & ~strobe_p1;
    assign last_section = (ACT_W'(k) + ACT_W'(1)) == active;

    // Sum stage: combine registered products, rescale and clamp
    always_comb begin
        acc_s = AW'(prod_b0_p1) + AW'(prod_b1_p1) + AW'(prod_b2_p1)
              - AW'(prod_a1_p1) - AW'(prod_a2_p1);
        y_s   = sat_int(acc_s >>> coefficient_Q);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            strobe_p0         <= 1'b0;
            strobe_p1         <= 1'b0;
            state             <= ST_IDLE;
            k                 <= '0;
            active            <= ACT_W'(sections);
            overrun           <= 1'b0;
            M_AXIS_out_tdata  <= '0;
            M_AXIS_out_tvalid <= 1'b0;
            v_p0              <= '0;
            prod_b0_p1        <= '0;
            prod_b1_p1        <= '0;
            prod_b2_p1        <= '0;
            prod_a1_p1        <= '0;
            prod_a2_p1        <= '0;
            for (int i = 0; i < sections; i++) begin
                coef_b0[i] <= CW'(64'sd1 <<< coefficient_Q);
                coef_b1[i] <= '0;
                coef_b2[i] <= '0;
                coef_a1[i] <= '0;
                coef_a2[i] <= '0;
                x1[i]      <= '0;
                x2[i]      <= '0;
                y1[i]      <= '0;
                y2[i]      <= '0;
            end
        end else begin
            // Stage p0: register the strobe once, keep its previous value for edge detect
            strobe_p0         <= axis_decii_clk;
            strobe_p1         <= strobe_p0;
            M_AXIS_out_tvalid <= 1'b0;

            if (cfg_ctrl) begin
                // Control word: new section count, clear history and abort any run
                active  <= cfg_active;
                overrun <= 1'b0;
                state   <= ST_IDLE;
                k       <= '0;
                for (int i = 0; i < sections; i++) begin
                    x1[i] <= '0;
                    x2[i] <= '0;
                    y1[i] <= '0;
                    y2[i] <= '0;
                end
            end else if (cfg_sec_any) begin
                state <= ST_IDLE;
                k     <= '0;
                for (int i = 0; i < sections; i++) begin
                    if (cfg_sec_hit[i]) begin
                        coef_b0[i] <= config_data[0   +: CW];
                        coef_b1[i] <= config_data[32  +: CW];
                        coef_b2[i] <= config_data[64  +: CW];
                        coef_a1[i] <= config_data[128 +: CW];
                        coef_a2[i] <= config_data[160 +: CW];
                        x1[i]      <= '0;
                        x2[i]      <= '0;
                        y1[i]      <= '0;
                        y2[i]      <= '0;
                    end
                end
            end else begin
                if (strobe_rise && state != ST_IDLE)
                    overrun <= 1'b1;

                case (state)
                    ST_IDLE: begin
                        if (strobe_rise) begin
                            v_p0  <= IW'(S_AXIS_in_tdata) <<< internal_extra;
                            k     <= '0;
                            state <= (active == '0) ? ST_OUT : ST_PROD;
                        end
                    end
                    // Stage p1: five products of the current section
                    ST_PROD: begin
                        prod_b0_p1 <= mul(coef_b0[k], v_p0);
                        prod_b1_p1 <= mul(coef_b1[k], x1[k]);
                        prod_b2_p1 <= mul(coef_b2[k], x2[k]);
                        prod_a1_p1 <= mul(coef_a1[k], y1[k]);
                        prod_a2_p1 <= mul(coef_a2[k], y2[k]);
                        state      <= ST_SUM;
                    end
                    // Stage p2: history update; section output feeds the next section
                    ST_SUM: begin
                        x2[k] <= x1[k];
                        x1[k] <= v_p0;
                        y2[k] <= y1[k];
                        y1[k] <= y_s;
                        v_p0  <= y_s;
                        if (last_section) begin
                            state <= ST_OUT;
                        end else begin
                            k     <= k + IDX_W'(1);
                            state <= ST_PROD;
                        end
                    end
                    default: begin
                        M_AXIS_out_tdata  <= sat_out(v_p0 >>> internal_extra);
                        M_AXIS_out_tvalid <= 1'b1;
                        state             <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_biquad_cascade_filter.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for axis_biquad_cascade_filter (default
// parameters: 32-bit data and coefficients, Q28, 4 guard bits, 4 sections,
// base address 999). Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_axis_biquad_cascade_filter;

    localparam int BASE = 999;
    localparam int NSEC = 4;

    logic               aclk;
    logic               aresetn;
    logic [31:0]        config_addr;
    logic [511:0]       config_data;
    logic signed [31:0] S_AXIS_in_tdata;
    logic               S_AXIS_in_tvalid;
    logic               axis_decii_clk;
    logic signed [31:0] M_AXIS_out_tdata;
    logic               M_AXIS_out_tvalid;
    logic signed [31:0] M_AXIS_pass_tdata;
    logic               M_AXIS_pass_tvalid;
    logic               overrun;

    int pass_cnt;
    int total_cnt;

    axis_biquad_cascade_filter dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .config_addr        (config_addr),
        .config_data        (config_data),
        .S_AXIS_in_tdata    (S_AXIS_in_tdata),
        .S_AXIS_in_tvalid   (S_AXIS_in_tvalid),
        .axis_decii_clk     (axis_decii_clk),
        .M_AXIS_out_tdata   (M_AXIS_out_tdata),
        .M_AXIS_out_tvalid  (M_AXIS_out_tvalid),
        .M_AXIS_pass_tdata  (M_AXIS_pass_tdata),
        .M_AXIS_pass_tvalid (M_AXIS_pass_tvalid),
        .overrun            (overrun)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // One-cycle write on the config bus, then park the address off-range
    task automatic write_cfg(input int offset, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w4,
                             input logic [31:0] w5);
        @(posedge aclk); #1;
        config_addr = 32'(BASE + offset);
        config_data = {320'b0, w5, w4, 32'h0, w2, w1, w0};
        @(posedge aclk); #1;
        config_addr = 32'h0;
        config_data = '0;
    endtask

    // One strobe; lat = cycles from the cycle the registered strobe is high
    // (the first clock edge only registers it) to the first valid sample.
    task automatic run_sample(input logic signed [31:0] din, output logic signed [31:0] dout,
                              output int lat, output int width);
        lat   = -1;
        width = 0;
        dout  = '0;
        @(posedge aclk); #1;
        S_AXIS_in_tdata = din;
        axis_decii_clk  = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge aclk); #1;
            if (c == 1) axis_decii_clk = 1'b0;
            if (M_AXIS_out_tvalid) begin
                if (lat < 0) begin
                    lat  = c - 1;
                    dout = M_AXIS_out_tdata;
                end
                width++;
            end else if (lat >= 0) begin
                break;
            end
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        total_cnt++;
        if (M_AXIS_out_tdata !== 32'sd0 || M_AXIS_out_tvalid !== 1'b0 || overrun !== 1'b0)
            $display("FAIL reset_outputs: got data=%0d valid=%0b overrun=%0b, need 0/0/0",
                     M_AXIS_out_tdata, M_AXIS_out_tvalid, overrun);
        else pass_cnt++;
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        total_cnt++;
        if (M_AXIS_out_tvalid !== 1'b0 || overrun !== 1'b0)
            $display("FAIL reset_release: got valid=%0b overrun=%0b, need 0/0",
                     M_AXIS_out_tvalid, overrun);
        else pass_cnt++;
    endtask

    task automatic test_passthrough();
        logic signed [31:0] val;
        val = -32'sd123456;
        S_AXIS_in_tdata  = val;
        S_AXIS_in_tvalid = 1'b1;
        #1;
        total_cnt++;
        if (M_AXIS_pass_tdata !== val || M_AXIS_pass_tvalid !== 1'b1)
            $display("FAIL pass_port: got %0d/%0b, need %0d/1",
                     M_AXIS_pass_tdata, M_AXIS_pass_tvalid, val);
        else pass_cnt++;
        S_AXIS_in_tvalid = 1'b0;
        #1;
        total_cnt++;
        if (M_AXIS_pass_tvalid !== 1'b0)
            $display("FAIL pass_valid_low: got %0b, need 0", M_AXIS_pass_tvalid);
        else pass_cnt++;
    endtask

    task automatic test_identity(input string tag);
        logic signed [31:0] d;
        int lat, w;
        run_sample(32'sd1000, d, lat, w);
        total_cnt++;
        if (d !== 32'sd1000) $display("FAIL %s_value: got %0d, need 1000", tag, d);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 10) $display("FAIL %s_latency: got %0d, need 10", tag, lat);
        else pass_cnt++;
        total_cnt++;
        if (w !== 1) $display("FAIL %s_pulse_width: got %0d, need 1", tag, w);
        else pass_cnt++;
        repeat (5) @(posedge aclk);
        #1;
        total_cnt++;
        if (M_AXIS_out_tdata !== 32'sd1000 || M_AXIS_out_tvalid !== 1'b0)
            $display("FAIL %s_hold: got %0d/%0b, need 1000/0", tag, M_AXIS_out_tdata,
                     M_AXIS_out_tvalid);
        else pass_cnt++;
    endtask

    task automatic test_fir();
        logic signed [31:0] d;
        logic signed [31:0] inp [4];
        logic signed [31:0] exp_out [4];
        int lat, w;
        inp     = '{32'sd1048576, 32'sd0, 32'sd0, 32'sd0};
        exp_out = '{32'sd524288, 32'sd524288, 32'sd0, 32'sd0};
        write_cfg(0, 32'h0800_0000, 32'h0800_0000, 32'h0, 32'h0, 32'h0);
        write_cfg(NSEC, 32'd1, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            run_sample(inp[i], d, lat, w);
            total_cnt++;
            if (d !== exp_out[i])
                $display("FIR_out%0d FAIL: got %0d, need %0d", i, d, exp_out[i]);
            else pass_cnt++;
            if (i == 0) begin
                total_cnt++;
                if (lat !== 4) $display("FAIL fir_latency: got %0d, need 4", lat);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_recursive();
        logic signed [31:0] d;
        logic signed [31:0] exp_out [4];
        int lat, w;
        exp_out = '{32'sd1024, 32'sd1536, 32'sd1792, 32'sd1920};
        write_cfg(0, 32'h1000_0000, 32'h0, 32'h0, 32'hF800_0000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            run_sample(32'sd1024, d, lat, w);
            total_cnt++;
            if (d !== exp_out[i])
                $display("FAIL recursive_out%0d: got %0d, need %0d", i, d, exp_out[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_saturation();
        logic signed [31:0] d;
        int lat, w;
        write_cfg(0, 32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0);
        run_sample(32'sh4000_0000, d, lat, w);
        total_cnt++;
        if (d !== 32'sh7FFF_FFFF) $display("FAIL sat_pos: got %0h, need 7fffffff", d);
        else pass_cnt++;
        run_sample(-32'sh4000_0000, d, lat, w);
        total_cnt++;
        if (d !== 32'sh8000_0000) $display("FAIL sat_neg: got %0h, need 80000000", d);
        else pass_cnt++;
    endtask

    task automatic test_active_bounds();
        logic signed [31:0] d;
        int lat, w;
        write_cfg(NSEC, 32'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        run_sample(-32'sd5, d, lat, w);
        total_cnt++;
        if (d !== -32'sd5 || lat !== 2)
            $display("FAIL active0_bypass: got %0d lat %0d, need -5 lat 2", d, lat);
        else pass_cnt++;
        write_cfg(0, 32'h1000_0000, 32'h0, 32'h0, 32'h0, 32'h0);
        write_cfg(NSEC, 32'd15, 32'h0, 32'h0, 32'h0, 32'h0);
        run_sample(32'sd3, d, lat, w);
        total_cnt++;
        if (d !== 32'sd3 || lat !== 10)
            $display("FAIL active_clamp: got %0d lat %0d, need 3 lat 10", d, lat);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        int pulses;
        logic signed [31:0] d;
        pulses = 0;
        d      = '0;
        @(posedge aclk); #1;
        S_AXIS_in_tdata = 32'sd77;
        axis_decii_clk  = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge aclk); #1;
            if (c == 1) axis_decii_clk = 1'b0;
            if (c == 3) begin
                axis_decii_clk  = 1'b1;
                S_AXIS_in_tdata = 32'sd99;
            end
            if (c == 4) axis_decii_clk = 1'b0;
            if (M_AXIS_out_tvalid) begin
                pulses++;
                d = M_AXIS_out_tdata;
            end
        end
        total_cnt++;
        if (pulses !== 1) $display("FAIL overrun_pulses: got %0d, need 1", pulses);
        else pass_cnt++;
        total_cnt++;
        if (d !== 32'sd77) $display("FAIL overrun_value: got %0d, need 77", d);
        else pass_cnt++;
        total_cnt++;
        if (overrun !== 1'b1) $display("FAIL overrun_set: got %0b, need 1", overrun);
        else pass_cnt++;
        write_cfg(NSEC, 32'd4, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL overrun_clear: got %0b, need 0", overrun);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int pulses;
        logic signed [31:0] d;
        int lat, w;
        pulses = 0;
        run_sample(32'sd555, d, lat, w);
        total_cnt++;
        if (d !== 32'sd555) $display("FAIL pre_reset_value: got %0d, need 555", d);
        else pass_cnt++;
        @(posedge aclk); #1;
        S_AXIS_in_tdata = 32'sd321;
        axis_decii_clk  = 1'b1;
        // edge 1 registers the strobe, edges 2..7 step P0 S0 P1 S1 P2 S2
        for (int c = 1; c <= 7; c++) begin
            @(posedge aclk); #1;
            if (c == 1) axis_decii_clk = 1'b0;
        end
        aresetn = 1'b0;
        #1;
        total_cnt++;
        if (M_AXIS_out_tdata !== 32'sd0 || M_AXIS_out_tvalid !== 1'b0)
            $display("FAIL async_reset_outputs: got %0d/%0b, need 0/0", M_AXIS_out_tdata,
                     M_AXIS_out_tvalid);
        else pass_cnt++;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge aclk); #1;
            if (M_AXIS_out_tvalid) pulses++;
        end
        total_cnt++;
        if (pulses !== 0) $display("FAIL async_reset_no_pulse: got %0d pulses, need 0", pulses);
        else pass_cnt++;
        test_identity("post_reset_identity");
    endtask

    initial begin
        pass_cnt         = 0;
        total_cnt        = 0;
        aresetn          = 1'b0;
        config_addr      = 32'h0;
        config_data      = '0;
        S_AXIS_in_tdata  = '0;
        S_AXIS_in_tvalid = 1'b0;
        axis_decii_clk   = 1'b0;

        test_reset();
        test_passthrough();
        test_identity("identity");
        test_fir();
        test_recursive();
        test_saturation();
        test_active_bounds();
        test_overrun();
        test_async_reset();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
